// File: rtl/wam_pkg.sv
// Shared constants and helpers for the Whac-A-Mole mole scheduler.
// Latency: n/a (package only).
// Backpressure: n/a.
package wam_pkg;

    localparam int NH_MAX = 16;
    localparam int LFSR_W = 16;
    localparam int LIFE_W = 4;
    localparam int CNT_W  = 5;
    localparam int RND_W  = 7;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
    localparam logic [LFSR_W-1:0] DEF_SEED  = 16'hACE1;

    // Per-cycle event counts, registered together
    typedef struct packed {
        logic [CNT_W-1:0] n_hit;
        logic [CNT_W-1:0] n_mis;
        logic [CNT_W-1:0] n_bad;
    } cnt_t;

    // Shift left, XOR of tapped bits enters at bit 0
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

    // Population count of a hole vector (zero-extended to NH_MAX)
    function automatic logic [CNT_W-1:0] pop_cnt(input logic [NH_MAX-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < NH_MAX; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/wam_lfsr.sv
// 16-bit Fibonacci LFSR supplying the spawn random number and hole index.
// Latency: advances one step on the edge where en=1; load of SEED on clr_n=0.
// Backpressure: none; en=0 holds the current value.
module wam_lfsr
    import wam_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEF_SEED
) (
    input  logic              clk_19,
    input  logic              clr_n,
    input  logic              en,
    output logic [LFSR_W-1:0] state
);

    // Reload seed on reset, otherwise step only when enabled
    always_ff @(posedge clk_19) begin
        if (!clr_n) begin
            state <= SEED;
        end else if (en) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/wam_sch.sv
// Mole scheduler: spawns, ages, expires moles and resolves whacks per game tick.
// Latency: all decisions use registered state; mole and counts update one edge later.
// Backpressure: none; run=0 freezes state and drops tick/hit.
module wam_sch
    import wam_pkg::*;
#(
    parameter int                NH   = 16,
    parameter int                MAXM = 3,
    parameter logic [LFSR_W-1:0] SEED = DEF_SEED
) (
    input  logic              clk_19,
    input  logic              clr_n,
    input  logic              run,
    input  logic              tick,
    input  logic [LIFE_W-1:0] age,
    input  logic [7:0]        rto,
    input  logic [NH-1:0]     hit,
    output logic [NH-1:0]     mole,
    output logic [2:0]        live,
    output logic [CNT_W-1:0]  hit_n,
    output logic [CNT_W-1:0]  mis_n,
    output logic [CNT_W-1:0]  bad_n
);

    localparam int         IDX_W  = (NH > 1) ? $clog2(NH) : 1;
    localparam logic [2:0] MAXM_L = 3'(MAXM);

    logic [LFSR_W-1:0] lfsr;
    logic [LIFE_W-1:0] life     [NH];
    logic [LIFE_W-1:0] life_nxt [NH];
    logic [NH-1:0]     hit_ok;
    logic [NH-1:0]     hit_bad;
    logic [NH-1:0]     expire;
    logic [IDX_W-1:0]  idx;
    logic [RND_W-1:0]  rnd;
    logic [LIFE_W-1:0] spawn_life;
    logic              step;
    logic              spawn;
    cnt_t              cnt_nxt;
    cnt_t              cnt_q;
    logic              unused_lfsr_bits;

    assign step = run & tick;

    wam_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk_19 (clk_19),
        .clr_n  (clr_n),
        .en     (step),
        .state  (lfsr)
    );

    // Only some LFSR bits feed decisions; fold the rest away
    assign unused_lfsr_bits = ^lfsr;

    // A hole is lit while its life counter is non-zero
    always_comb begin
        mole = '0;
        for (int i = 0; i < NH; i++) begin
            mole[i] = (life[i] != '0);
        end
    end

    assign live       = 3'(pop_cnt(NH_MAX'(mole)));
    assign idx        = lfsr[12 +: IDX_W];
    assign rnd        = lfsr[RND_W-1:0];
    assign spawn_life = (age == '0) ? LIFE_W'(1) : age;
    assign spawn      = step & ({1'b0, rnd} < rto) & ~mole[idx] & (live < MAXM_L);
    assign hit_ok     = run ? (hit & mole)  : '0;
    assign hit_bad    = run ? (hit & ~mole) : '0;

    // Per-hole next life: hit clears, tick ages/expires, spawn loads a free hole
    always_comb begin
        expire = '0;
        for (int i = 0; i < NH; i++) begin
            life_nxt[i] = life[i];
            if (hit_ok[i]) begin
                life_nxt[i] = '0;
            end else if (step && mole[i]) begin
                if (life[i] == LIFE_W'(1)) begin
                    life_nxt[i] = '0;
                    expire[i]   = 1'b1;
                end else begin
                    life_nxt[i] = life[i] - LIFE_W'(1);
                end
            end
            if (spawn && (idx == IDX_W'(i))) begin
                life_nxt[i] = spawn_life;
            end
        end
    end

    // Event counts for this cycle (all zero while paused)
    always_comb begin
        cnt_nxt       = '0;
        cnt_nxt.n_hit = pop_cnt(NH_MAX'(hit_ok));
        cnt_nxt.n_mis = pop_cnt(NH_MAX'(expire));
        cnt_nxt.n_bad = pop_cnt(NH_MAX'(hit_bad));
    end

    // Register life array and counts together so they stay aligned
    always_ff @(posedge clk_19) begin
        if (!clr_n) begin
            for (int i = 0; i < NH; i++) begin
                life[i] <= '0;
            end
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < NH; i++) begin
                life[i] <= life_nxt[i];
            end
            cnt_q <= cnt_nxt;
        end
    end

    assign hit_n = cnt_q.n_hit;
    assign mis_n = cnt_q.n_mis;
    assign bad_n = cnt_q.n_bad;

endmodule

// File: tb/tb_wam_sch.sv
// Directed bench for wam_sch with hand-derived LFSR sequence from 16'hACE1:
// ACE1 (idx 10, rnd 97), 59C3 (idx 5, rnd 67), B387, 670F, CE1E (idx 12, rnd 30).
module tb_wam_sch;

    logic        clk_19 = 1'b0;
    logic        clr_n;
    logic        run;
    logic        tick;
    logic [3:0]  age;
    logic [7:0]  rto;
    logic [15:0] hit;
    logic [15:0] mole;
    logic [2:0]  live;
    logic [4:0]  hit_n;
    logic [4:0]  mis_n;
    logic [4:0]  bad_n;

    int checks   = 0;
    int failures = 0;
    int max_live = 0;

    wam_sch #(
        .NH   (16),
        .MAXM (3),
        .SEED (16'hACE1)
    ) dut (
        .clk_19 (clk_19),
        .clr_n  (clr_n),
        .run    (run),
        .tick   (tick),
        .age    (age),
        .rto    (rto),
        .hit    (hit),
        .mole   (mole),
        .live   (live),
        .hit_n  (hit_n),
        .mis_n  (mis_n),
        .bad_n  (bad_n)
    );

    always #5 clk_19 = ~clk_19;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the edge
    task automatic cyc(input logic r, input logic t, input logic [15:0] h);
        run  = r;
        tick = t;
        hit  = h;
        @(posedge clk_19);
        #1;
    endtask

    task automatic do_reset();
        clr_n = 1'b0;
        run   = 1'b0;
        tick  = 1'b0;
        hit   = '0;
        @(posedge clk_19);
        #1;
        clr_n = 1'b1;
    endtask

    initial begin
        // Reset with noise on hit/tick
        clr_n = 1'b0;
        run   = 1'b1;
        age   = 4'd3;
        rto   = 8'd200;
        for (int k = 0; k < 3; k++) begin
            tick = 1'($urandom);
            hit  = 16'($urandom);
            @(posedge clk_19);
            #1;
        end
        chk("rst_mole", mole, 16'h0000);
        chk("rst_live", 16'(live), 16'd0);
        chk("rst_hit_n", 16'(hit_n), 16'd0);
        chk("rst_mis_n", 16'(mis_n), 16'd0);
        chk("rst_bad_n", 16'(bad_n), 16'd0);

        // Basic spawn in hole 10, lifetime 3, then expire
        clr_n = 1'b1;
        cyc(1, 1, 16'h0000);
        chk("spawn_mole", mole, 16'h0400);
        chk("spawn_live", 16'(live), 16'd1);
        rto = 8'd0;
        cyc(1, 1, 16'h0000);
        chk("age2_mole", mole, 16'h0400);
        cyc(1, 1, 16'h0000);
        chk("age1_mole", mole, 16'h0400);
        chk("age1_mis", 16'(mis_n), 16'd0);
        cyc(1, 1, 16'h0000);
        chk("exp_mole", mole, 16'h0000);
        chk("exp_mis", 16'(mis_n), 16'd1);
        chk("exp_live", 16'(live), 16'd0);
        cyc(1, 0, 16'h0000);
        chk("exp_mis_pulse", 16'(mis_n), 16'd0);

        // age=0 behaves as lifetime 1
        do_reset();
        age = 4'd0;
        rto = 8'd200;
        cyc(1, 1, 16'h0000);
        chk("age0_mole", mole, 16'h0400);
        rto = 8'd0;
        cyc(1, 1, 16'h0000);
        chk("age0_exp_mole", mole, 16'h0000);
        chk("age0_exp_mis", 16'(mis_n), 16'd1);

        // Hit beats expiry on the same tick
        do_reset();
        age = 4'd1;
        rto = 8'd200;
        cyc(1, 1, 16'h0000);
        chk("hve_spawn", mole, 16'h0400);
        rto = 8'd0;
        cyc(1, 1, 16'h0400);
        chk("hve_hit_n", 16'(hit_n), 16'd1);
        chk("hve_mis_n", 16'(mis_n), 16'd0);
        chk("hve_bad_n", 16'(bad_n), 16'd0);
        chk("hve_mole", mole, 16'h0000);

        // Strict threshold: rnd==rto does not spawn, rnd<rto does
        do_reset();
        age = 4'd3;
        rto = 8'd97;
        cyc(1, 1, 16'h0000);
        chk("thr_eq_mole", mole, 16'h0000);
        rto = 8'd68;
        cyc(1, 1, 16'h0000);
        chk("thr_lt_mole", mole, 16'h0020);

        // Whack on a just-spawned hole is bad; then simultaneous hits + bad
        do_reset();
        age = 4'd3;
        rto = 8'd200;
        cyc(1, 1, 16'h0000);
        chk("multi_m10", mole, 16'h0400);
        cyc(1, 1, 16'h0020);
        chk("multi_m5", mole, 16'h0420);
        chk("multi_live2", 16'(live), 16'd2);
        chk("spawn_hit_bad", 16'(bad_n), 16'd1);
        chk("spawn_hit_hit", 16'(hit_n), 16'd0);
        rto = 8'd0;
        cyc(1, 0, 16'h0421);
        chk("multi_hit_n", 16'(hit_n), 16'd2);
        chk("multi_bad_n", 16'(bad_n), 16'd1);
        chk("multi_mis_n", 16'(mis_n), 16'd0);
        chk("multi_live0", 16'(live), 16'd0);
        chk("multi_mole", mole, 16'h0000);

        // Pause holds life and LFSR, ignores tick and hits
        do_reset();
        age = 4'd3;
        rto = 8'd200;
        cyc(1, 1, 16'h0000);
        rto = 8'd0;
        cyc(1, 1, 16'h0000);
        chk("pause_pre", mole, 16'h0400);
        for (int k = 0; k < 10; k++) begin
            cyc(0, 1, 16'hFFFF);
            chk("pause_mole", mole, 16'h0400);
            chk("pause_hit_n", 16'(hit_n), 16'd0);
            chk("pause_bad_n", 16'(bad_n), 16'd0);
            chk("pause_mis_n", 16'(mis_n), 16'd0);
        end
        cyc(1, 1, 16'h0000);
        chk("resume_life1", mole, 16'h0400);
        chk("resume_mis0", 16'(mis_n), 16'd0);
        cyc(1, 1, 16'h0000);
        chk("resume_exp", mole, 16'h0000);
        chk("resume_mis1", 16'(mis_n), 16'd1);
        age = 4'd2;
        rto = 8'd31;
        cyc(1, 1, 16'h0000);
        chk("resume_lfsr_held", mole, 16'h1000);

        // Suppression then cap at MAXM
        do_reset();
        rto = 8'd0;
        age = 4'd15;
        for (int k = 0; k < 100; k++) begin
            cyc(1, 1, 16'h0000);
            chk("supp_mole", mole, 16'h0000);
        end
        rto = 8'd255;
        for (int k = 0; k < 20; k++) begin
            cyc(1, 1, 16'h0000);
            chk("cap_le_maxm", 16'(live <= 3'd3), 16'd1);
            chk("cap_popcount", 16'(live), 16'($countones(mole)));
            if (int'(live) > max_live) max_live = int'(live);
        end
        chk("cap_reached", 16'(max_live), 16'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
